// File: rtl/unified_mem_arbiter.sv
// Unified memory arbiter: shares one single-port instruction/data memory
// between the fetch stage and the load/store stage. Data has fixed priority,
// and a bounded starvation counter lets fetch through after STARVE_MAX
// consecutive denied cycles. Read data is routed back to the owner of the
// previous cycle's grant.
module unified_mem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

    owner_t     owner_q;
    owner_t     owner_d;
    logic       owner_we_q;
    logic [3:0] starve_cnt;
    logic       fetch_boost;

    // Byte-offset bits are irrelevant to a word-addressed memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

    assign fetch_boost = (starve_cnt == 4'(STARVE_MAX));

    // Same-cycle grant decision; data wins unless fetch has starved long enough.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!rst) begin
            d_gnt  = d_req && !fetch_boost;
            if_gnt = if_req && (!d_req || fetch_boost);
        end
    end

    // Steer the granted requester onto the memory port; fetch is always a full-word read.
    always_comb begin
        mem_en    = if_gnt || d_gnt;
        mem_we    = 1'b0;
        mem_addr  = if_addr[ADDR_W-1:2];
        mem_wdata = 32'h0;
        mem_be    = 4'b1111;
        if (d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr[ADDR_W-1:2];
            mem_wdata = d_wdata;
            mem_be    = d_we ? d_be : 4'b1111;
        end
    end

    // Owner register remembers who gets the memory response next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q    <= OWN_NONE;
            owner_we_q <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            owner_we_q <= d_gnt && d_we;
        end
    end

    // Next owner follows the current grant.
    always_comb begin
        owner_d = OWN_NONE;
        if (d_gnt) begin
            owner_d = OWN_DATA;
        end else if (if_gnt) begin
            owner_d = OWN_FETCH;
        end
    end

    // Route the synchronous read data to the owner; stores get a zero-data acknowledge.
    always_comb begin
        if_valid = 1'b0;
        if_rdata = 32'h0;
        d_valid  = 1'b0;
        d_rdata  = 32'h0;
        case (owner_q)
            OWN_FETCH: begin
                if_valid = 1'b1;
                if_rdata = mem_rdata;
            end
            OWN_DATA: begin
                d_valid = 1'b1;
                d_rdata = owner_we_q ? 32'h0 : mem_rdata;
            end
            default: begin
                if_valid = 1'b0;
            end
        endcase
    end

    // Consecutive-denial counter that forces a fetch grant once it saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (!if_req || if_gnt) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != 4'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Saturating count of fetch-stall cycles for performance monitoring.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (if_req && !if_gnt && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed testbench for unified_mem_arbiter with a behavioural synchronous
// byte-enabled memory model attached to the mem_* port.
module tb_unified_mem_arbiter;

    localparam int ADDR_W     = 8;
    localparam int STARVE_MAX = 3;

    logic              clk;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_be;
    logic              d_gnt;
    logic              d_valid;
    logic [31:0]       d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;
    logic [15:0]       stall_cnt;

    logic [31:0] mem_array [0:63];

    int n_assert;
    int n_fail;

    unified_mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_valid (if_valid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_be     (d_be),
        .d_gnt    (d_gnt),
        .d_valid  (d_valid),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be   (mem_be),
        .mem_rdata(mem_rdata),
        .stall_cnt(stall_cnt)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory: byte-masked writes, registered reads.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) begin
                        mem_array[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                    end
                end
            end else begin
                mem_rdata <= mem_array[mem_addr];
            end
        end
    end

    // Advance one cycle, drive all requester inputs just after the edge, let them settle.
    task automatic applyStimulus(input logic ifr, input logic [ADDR_W-1:0] ifa,
                                 input logic dr, input logic dwe,
                                 input logic [ADDR_W-1:0] da, input logic [31:0] dwd,
                                 input logic [3:0] dbe);
        @(posedge clk);
        #1;
        if_req  = ifr;
        if_addr = ifa;
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
        d_be    = dbe;
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1;
        rst     = 1'b1;
        if_req  = 1'b0;
        d_req   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        for (int i = 0; i < 64; i++) begin
            mem_array[i] = 32'h0;
        end
        mem_array[4] = 32'h0000_0033;
        mem_rdata    = 32'h0;

        // Reset held with both requesters asking.
        rst     = 1'b1;
        if_req  = 1'b1;
        if_addr = 8'h10;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 8'h00;
        d_wdata = 32'h0;
        d_be    = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        #3;
        checkOutput("rst_if_gnt", 32'(if_gnt), 32'd0);
        checkOutput("rst_d_gnt", 32'(d_gnt), 32'd0);
        checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
        checkOutput("rst_d_valid", 32'(d_valid), 32'd0);
        checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);

        // Release reset: data wins in the very first cycle.
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        checkOutput("rel_d_gnt", 32'(d_gnt), 32'd1);
        checkOutput("rel_if_gnt", 32'(if_gnt), 32'd0);
        checkOutput("rel_mem_en", 32'(mem_en), 32'd1);

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 4'b0000);
        checkOutput("rel_d_valid", 32'(d_valid), 32'd1);
        checkOutput("rel_d_rdata", d_rdata, 32'h0);
        checkOutput("rel_stall_cnt", 32'(stall_cnt), 32'd1);

        // Lone fetch from word 4.
        applyStimulus(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 32'h0, 4'b0000);
        checkOutput("fetch_if_gnt", 32'(if_gnt), 32'd1);
        checkOutput("fetch_mem_addr", 32'(mem_addr), 32'd4);
        checkOutput("fetch_mem_we", 32'(mem_we), 32'd0);
        checkOutput("fetch_mem_be", 32'(mem_be), 32'hF);
        applyStimulus(1'b0, 8'h10, 1'b0, 1'b0, 8'h00, 32'h0, 4'b0000);
        checkOutput("fetch_if_valid", 32'(if_valid), 32'd1);
        checkOutput("fetch_if_rdata", if_rdata, 32'h0000_0033);
        checkOutput("fetch_d_valid", 32'(d_valid), 32'd0);
        applyStimulus(1'b0, 8'h10, 1'b0, 1'b0, 8'h00, 32'h0, 4'b0000);
        checkOutput("idle_if_valid", 32'(if_valid), 32'd0);
        checkOutput("idle_if_rdata", if_rdata, 32'h0);

        // Starvation: fetch must break through every STARVE_MAX+1 cycles.
        pulseReset();
        for (int i = 0; i < 12; i++) begin
            logic exp_if;
            exp_if = (i == 3) || (i == 7) || (i == 11);
            applyStimulus(1'b1, 8'h20, 1'b1, 1'b0, 8'h24, 32'h0, 4'b0000);
            checkOutput($sformatf("starve_if_gnt_%0d", i), 32'(if_gnt), 32'(exp_if));
            checkOutput($sformatf("starve_d_gnt_%0d", i), 32'(d_gnt), 32'(!exp_if));
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 4'b0000);
        checkOutput("starve_stall_cnt", 32'(stall_cnt), 32'd9);
        checkOutput("starve_last_if_valid", 32'(if_valid), 32'd1);

        // Store then load of the same word in consecutive cycles.
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h0C, 32'hDEAD_BEEF, 4'b1111);
        checkOutput("st_d_gnt", 32'(d_gnt), 32'd1);
        checkOutput("st_mem_we", 32'(mem_we), 32'd1);
        checkOutput("st_mem_addr", 32'(mem_addr), 32'd3);
        checkOutput("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h0C, 32'h0, 4'b0010);
        checkOutput("st_ack_valid", 32'(d_valid), 32'd1);
        checkOutput("st_ack_rdata", d_rdata, 32'h0);
        checkOutput("ld_mem_be", 32'(mem_be), 32'hF);
        checkOutput("ld_mem_we", 32'(mem_we), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 4'b0000);
        checkOutput("ld_d_valid", 32'(d_valid), 32'd1);
        checkOutput("ld_d_rdata", d_rdata, 32'hDEAD_BEEF);

        // Byte-masked store into a known word.
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h0C, 32'h1122_3344, 4'b1111);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h0C, 32'hAABB_CCDD, 4'b0010);
        checkOutput("bst_mem_be", 32'(mem_be), 32'h2);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h0C, 32'h0, 4'b0000);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 4'b0000);
        checkOutput("bst_d_valid", 32'(d_valid), 32'd1);
        checkOutput("bst_d_rdata", d_rdata, 32'h1122_CC44);

        // Reset pulsed right after a load grant drops its response.
        pulseReset();
        applyStimulus(1'b1, 8'h10, 1'b1, 1'b0, 8'h0C, 32'h0, 4'b0000);
        applyStimulus(1'b1, 8'h10, 1'b1, 1'b0, 8'h0C, 32'h0, 4'b0000);
        checkOutput("mrst_d_gnt", 32'(d_gnt), 32'd1);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        if_req = 1'b0;
        d_req  = 1'b0;
        #2;
        checkOutput("mrst_d_valid_in_rst", 32'(d_valid), 32'd0);
        checkOutput("mrst_d_rdata_in_rst", d_rdata, 32'h0);
        checkOutput("mrst_mem_en_in_rst", 32'(mem_en), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        checkOutput("mrst_d_valid_after", 32'(d_valid), 32'd0);
        checkOutput("mrst_stall_cnt", 32'(stall_cnt), 32'd0);
        checkOutput("mrst_starve_cnt", 32'(dut.starve_cnt), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 4'b0000);
        checkOutput("mrst_d_valid_later", 32'(d_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
